// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the push-button conditioning stage.
// Auto-repeat is compiled in only when KEY_CONDITIONER_AUTOREPEAT_EN is defined.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_ON  = 2'd1,
        HELD     = 2'd2,
        PEND_OFF = 2'd3
    } key_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 4;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce FSM, press/release pulses.
// Optional auto-repeat under KEY_CONDITIONER_AUTOREPEAT_EN.
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN       = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    key_state_e      state;
    key_state_e      state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            press_n;
    logic            release_n;
    logic            rep_pulse;

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        REPEAT_EN < 0 || REPEAT_EN > 1) begin : g_bad_param
        $error("key_debounce_ch: invalid parameter value");
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_n = PEND_ON;
                    cnt_n   = '0;
                end
            end
            PEND_ON: begin
                if (!s2) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_n = PEND_OFF;
                    cnt_n   = '0;
                end else begin
                    press_n = rep_pulse;
                end
            end
            PEND_OFF: begin
                if (s2) begin
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            s1          <= key_raw;
            s2          <= s1;
            state       <= state_n;
            cnt         <= cnt_n;
            key_level   <= (state_n == HELD) || (state_n == PEND_OFF);
            key_press   <= press_n;
            key_release <= release_n;
        end
    end

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    if (REPEAT_EN != 0) begin : g_repeat
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                              REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW = cnt_width(RMAX);
        localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

        logic [RW-1:0] rcnt;
        logic          in_delay;
        logic          hold_on;

        // Counts only while HELD is kept; any exit or bounce restarts the delay.
        assign hold_on   = (state == HELD) && s2;
        assign rep_pulse = hold_on &&
                           (rcnt == (in_delay ? DELAY_LAST : PERIOD_LAST));

        always_ff @(posedge clk) begin
            if (rst || !hold_on) begin
                rcnt     <= '0;
                in_delay <= 1'b1;
            end else if (rep_pulse) begin
                rcnt     <= '0;
                in_delay <= 1'b0;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end else begin : g_no_repeat
        assign rep_pulse = 1'b0;
    end
`else
    assign rep_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Debounces N_KEYS push-buttons into levels and press/release pulses.
// Auto-repeat for REPEAT_MASK keys needs KEY_CONDITIONER_AUTOREPEAT_EN.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int                N_KEYS          = 3,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = N_KEYS'(3'b010)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY_RAW,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (int'(REPEAT_MASK[i]))
        ) u_ch (
            .clk         (CLK),
            .rst         (RESET),
            .key_raw     (KEY_RAW[i]),
            .key_level   (KEY_LEVEL[i]),
            .key_press   (KEY_PRESS[i]),
            .key_release (KEY_RELEASE[i])
        );
    end

endmodule
